// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle controller and its datapath:
// the instruction opcode and memory handshake come in, and the steering-mux
// selects and load enables go out.
interface multicycle_controller_if #(
    parameter int OPCODE_W = 4,
    parameter int ALUOP_W  = 2
);
    logic [OPCODE_W-1:0] opcode;
    logic                mem_ready;
    logic                ior;
    logic                mem_read;
    logic                mem_write;
    logic                ir_write;
    logic                pc_write;
    logic                pc_write_cond;
    logic [1:0]          pc_src;
    logic                alu_src_a;
    logic [1:0]          alu_src_b;
    logic [ALUOP_W-1:0]  alu_op;
    logic                reg_dst;
    logic                mem_to_reg;
    logic                reg_write;
    logic                instr_done;
    logic                illegal_op;
    logic                halted;

    // Controller side
    modport master (
        input  opcode, mem_ready,
        output ior, mem_read, mem_write, ir_write, pc_write, pc_write_cond,
               pc_src, alu_src_a, alu_src_b, alu_op, reg_dst, mem_to_reg,
               reg_write, instr_done, illegal_op, halted
    );

    // Datapath side
    modport slave (
        output opcode, mem_ready,
        input  ior, mem_read, mem_write, ir_write, pc_write, pc_write_cond,
               pc_src, alu_src_a, alu_src_b, alu_op, reg_dst, mem_to_reg,
               reg_write, instr_done, illegal_op, halted
    );
endinterface

// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle datapath. Steps each instruction through
// fetch/decode/execute/memory/writeback and decodes the current state (plus
// mem_ready in the memory-access states) straight onto the mux selects, so
// an asynchronous reset removes every request immediately.
module multicycle_controller #(
    parameter int OPCODE_W = 4,
    parameter int ALUOP_W  = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    multicycle_controller_if.master  bus
);

    localparam logic [OPCODE_W-1:0] OP_R    = 4'b0000;
    localparam logic [OPCODE_W-1:0] OP_ADDI = 4'b0001;
    localparam logic [OPCODE_W-1:0] OP_LW   = 4'b0010;
    localparam logic [OPCODE_W-1:0] OP_SW   = 4'b0011;
    localparam logic [OPCODE_W-1:0] OP_BEQ  = 4'b0100;
    localparam logic [OPCODE_W-1:0] OP_J    = 4'b0101;
    localparam logic [OPCODE_W-1:0] OP_HALT = 4'b1111;

    localparam logic [ALUOP_W-1:0] ALU_ADD   = 2'b00;
    localparam logic [ALUOP_W-1:0] ALU_SUB   = 2'b01;
    localparam logic [ALUOP_W-1:0] ALU_FUNCT = 2'b10;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_EXEC_R   = 4'd3,
        S_R_WB     = 4'd4,
        S_EXEC_I   = 4'd5,
        S_I_WB     = 4'd6,
        S_MEM_ADDR = 4'd7,
        S_MEM_RD   = 4'd8,
        S_MEM_WB   = 4'd9,
        S_MEM_WR   = 4'd10,
        S_BRANCH   = 4'd11,
        S_JUMP     = 4'd12,
        S_HALT     = 4'd13
    } state_t;

    state_t state_r;
    state_t state_nxt_s;
    logic   illegal_r;
    logic   illegal_set_s;

    // State register; reset aborts any instruction in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Sticky flag recording that an undefined opcode was decoded
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_r <= 1'b0;
        end else if (illegal_set_s) begin
            illegal_r <= 1'b1;
        end else begin
            illegal_r <= illegal_r;
        end
    end

    assign bus.illegal_op = illegal_r;

    // Next-state selection and per-state decode of the control lines
    always_comb begin
        state_nxt_s       = state_r;
        illegal_set_s     = 1'b0;
        bus.ior           = 1'b0;
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.ir_write      = 1'b0;
        bus.pc_write      = 1'b0;
        bus.pc_write_cond = 1'b0;
        bus.pc_src        = 2'b00;
        bus.alu_src_a     = 1'b0;
        bus.alu_src_b     = 2'b00;
        bus.alu_op        = ALU_ADD;
        bus.reg_dst       = 1'b0;
        bus.mem_to_reg    = 1'b0;
        bus.reg_write     = 1'b0;
        bus.instr_done    = 1'b0;
        bus.halted        = 1'b0;

        case (state_r)
            S_IDLE: begin
                state_nxt_s = S_FETCH;
            end
            S_FETCH: begin
                // PC + 4 computed every cycle; committed only with the IR load
                bus.mem_read  = 1'b1;
                bus.alu_src_b = 2'b01;
                if (bus.mem_ready) begin
                    bus.ir_write = 1'b1;
                    bus.pc_write = 1'b1;
                    state_nxt_s  = S_DECODE;
                end else begin
                    state_nxt_s  = S_FETCH;
                end
            end
            S_DECODE: begin
                // Branch target precomputed into ALUOut
                bus.alu_src_b = 2'b11;
                case (bus.opcode)
                    OP_R:    state_nxt_s = S_EXEC_R;
                    OP_ADDI: state_nxt_s = S_EXEC_I;
                    OP_LW:   state_nxt_s = S_MEM_ADDR;
                    OP_SW:   state_nxt_s = S_MEM_ADDR;
                    OP_BEQ:  state_nxt_s = S_BRANCH;
                    OP_J:    state_nxt_s = S_JUMP;
                    OP_HALT: state_nxt_s = S_HALT;
                    default: begin
                        // Undefined opcode retires as a NOP
                        illegal_set_s  = 1'b1;
                        bus.instr_done = 1'b1;
                        state_nxt_s    = S_FETCH;
                    end
                endcase
            end
            S_EXEC_R: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = ALU_FUNCT;
                state_nxt_s   = S_R_WB;
            end
            S_R_WB: begin
                bus.reg_dst    = 1'b1;
                bus.reg_write  = 1'b1;
                bus.instr_done = 1'b1;
                state_nxt_s    = S_FETCH;
            end
            S_EXEC_I: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
                state_nxt_s   = S_I_WB;
            end
            S_I_WB: begin
                bus.reg_write  = 1'b1;
                bus.instr_done = 1'b1;
                state_nxt_s    = S_FETCH;
            end
            S_MEM_ADDR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
                if (bus.opcode == OP_LW) begin
                    state_nxt_s = S_MEM_RD;
                end else begin
                    state_nxt_s = S_MEM_WR;
                end
            end
            S_MEM_RD: begin
                bus.ior      = 1'b1;
                bus.mem_read = 1'b1;
                if (bus.mem_ready) begin
                    state_nxt_s = S_MEM_WB;
                end else begin
                    state_nxt_s = S_MEM_RD;
                end
            end
            S_MEM_WB: begin
                bus.mem_to_reg = 1'b1;
                bus.reg_write  = 1'b1;
                bus.instr_done = 1'b1;
                state_nxt_s    = S_FETCH;
            end
            S_MEM_WR: begin
                bus.ior       = 1'b1;
                bus.mem_write = 1'b1;
                if (bus.mem_ready) begin
                    bus.instr_done = 1'b1;
                    state_nxt_s    = S_FETCH;
                end else begin
                    state_nxt_s    = S_MEM_WR;
                end
            end
            S_BRANCH: begin
                bus.alu_src_a     = 1'b1;
                bus.alu_op        = ALU_SUB;
                bus.pc_src        = 2'b01;
                bus.pc_write_cond = 1'b1;
                bus.instr_done    = 1'b1;
                state_nxt_s       = S_FETCH;
            end
            S_JUMP: begin
                bus.pc_src     = 2'b10;
                bus.pc_write   = 1'b1;
                bus.instr_done = 1'b1;
                state_nxt_s    = S_FETCH;
            end
            S_HALT: begin
                bus.halted  = 1'b1;
                state_nxt_s = S_HALT;
            end
            default: begin
                // Unused encodings fall back to a clean restart
                state_nxt_s = S_IDLE;
            end
        endcase
    end

endmodule
